// File: rtl/uart_dump_pkg.sv
`default_nettype none
// ==========================================================================
// Package : uart_dump_pkg
// Brief   : Shared types and defaults for the UART acquisition-dump scheduler.
// Rev     : 1.0 - initial release
// ==========================================================================
package uart_dump_pkg;

  localparam int SAMPLE_W   = 16;
  localparam int DEF_ADDR_W = 22;
  localparam int DEF_DEPTH  = 4194304;
  localparam int DEF_CNT_W  = 24;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    CALC        = 3'd1,
    RD_REQ      = 3'd2,
    RD_WAIT     = 3'd3,
    TX_SEND     = 3'd4,
    TX_WAIT     = 3'd5,
    FINISH      = 3'd6,
    ABORT_DRAIN = 3'd7
  } state_t;

endpackage
`default_nettype wire

// File: rtl/uart_dump_scheduler_if.sv
`default_nettype none
// ==========================================================================
// Interface : uart_dump_scheduler_if
// Brief     : Sample-memory read port plus UART transmit handshake.
// Rev       : 1.0 - initial release
// ==========================================================================
interface uart_dump_scheduler_if
  import uart_dump_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
);

  logic                rd_req;
  logic [ADDR_W-1:0]   rd_addr;
  logic                rd_ready;
  logic                rd_valid;
  logic [SAMPLE_W-1:0] rd_data;
  logic                send_uart;
  logic [SAMPLE_W-1:0] send_msg;
  logic                tx_done;

  modport master (
    output rd_req, rd_addr, send_uart, send_msg,
    input  rd_ready, rd_valid, rd_data, tx_done
  );

  modport slave (
    input  rd_req, rd_addr, send_uart, send_msg,
    output rd_ready, rd_valid, rd_data, tx_done
  );

endinterface
`default_nettype wire

// File: rtl/dump_addr_gen.sv
`default_nettype none
// ==========================================================================
// Module : dump_addr_gen
// Brief  : Circular read-address generator and remaining-word counter.
// Rev    : 1.0 - initial release
// ==========================================================================
module dump_addr_gen
  import uart_dump_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk_PSRAM,
  input  logic              reset,
  input  logic              i_load,
  input  logic              i_step,
  input  logic [ADDR_W-1:0] i_trig_addr,
  input  logic [CNT_W-1:0]  i_before,
  input  logic [CNT_W:0]    i_total,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_rem_next_zero
);

  // Two guard bits hold trig + DEPTH without overflow; i_before <= DEPTH on load.
  localparam int              W       = ADDR_W + 2;
  localparam logic [W-1:0]    c_DEPTH = W'(DEPTH);

  logic [W-1:0]      w_sum;
  logic [ADDR_W-1:0] w_start;
  logic [ADDR_W-1:0] w_next_addr;
  logic [ADDR_W-1:0] r_addr;
  logic [CNT_W:0]    r_remaining;

  always_comb begin
    w_sum       = W'(i_trig_addr) + c_DEPTH - W'(i_before);
    w_start     = ADDR_W'((w_sum >= c_DEPTH) ? (w_sum - c_DEPTH) : w_sum);
    w_next_addr = ({2'b00, r_addr} == (c_DEPTH - W'(1))) ? '0 : (r_addr + ADDR_W'(1));
  end

  always_ff @(posedge clk_PSRAM) begin
    if (reset) begin
      r_addr      <= '0;
      r_remaining <= '0;
    end else if (i_load) begin
      r_addr      <= w_start;
      r_remaining <= i_total;
    end else if (i_step) begin
      r_addr      <= w_next_addr;
      r_remaining <= r_remaining - (CNT_W+1)'(1);
    end
  end

  // Zero flag of the post-decrement count, so the FSM can branch on the same edge it counts.
  assign o_rem_next_zero = (r_remaining == (CNT_W+1)'(1));
  assign o_addr          = r_addr;

endmodule
`default_nettype wire

// File: rtl/uart_dump_scheduler.sv
`default_nettype none
// ==========================================================================
// Module : uart_dump_scheduler
// Brief  : Streams a captured acquisition window from sample memory to UART.
// Rev    : 1.0 - initial release
// ==========================================================================
module uart_dump_scheduler
  import uart_dump_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                 clk_PSRAM,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [ADDR_W-1:0]    trig_addr,
  input  logic [CNT_W-1:0]     samples_before,
  input  logic [CNT_W-1:0]     samples_after,
  uart_dump_scheduler_if.master bus,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [CNT_W-1:0]     sent_cnt
);

  localparam logic [63:0] c_DEPTH64 = 64'(DEPTH);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_trig;
  logic [CNT_W-1:0]    r_before;
  logic [CNT_W-1:0]    r_after;
  logic                r_tx_done_d;
  logic                r_tx_edge;
  logic                r_rd_req;
  logic                r_send_uart;
  logic [SAMPLE_W-1:0] r_send_msg;
  logic                r_done;
  logic                r_err;
  logic [CNT_W-1:0]    r_sent_cnt;

  logic [CNT_W:0]      w_total;
  logic                w_bad;
  logic                w_load;
  logic                w_step;
  logic [ADDR_W-1:0]   w_addr;
  logic                w_last;

  always_comb begin
    w_total = {1'b0, r_before} + {1'b0, r_after};
    w_bad   = (w_total == '0) || (64'(w_total) > c_DEPTH64) || (64'(r_before) > c_DEPTH64);
    w_load  = (r_state == CALC) && !abort && !w_bad;
    w_step  = (r_state == TX_WAIT) && r_tx_edge && !abort;
  end

  dump_addr_gen #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) u_addr_gen (
    .clk_PSRAM       (clk_PSRAM),
    .reset           (reset),
    .i_load          (w_load),
    .i_step          (w_step),
    .i_trig_addr     (r_trig),
    .i_before        (r_before),
    .i_total         (w_total),
    .o_addr          (w_addr),
    .o_rem_next_zero (w_last)
  );

  always_ff @(posedge clk_PSRAM) begin
    if (reset) begin
      r_state     <= IDLE;
      r_trig      <= '0;
      r_before    <= '0;
      r_after     <= '0;
      r_tx_done_d <= 1'b0;
      r_tx_edge   <= 1'b0;
      r_rd_req    <= 1'b0;
      r_send_uart <= 1'b0;
      r_send_msg  <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_sent_cnt  <= '0;
    end else begin
      // Registered edge: a tx_done level left high by the previous word never fires.
      r_tx_done_d <= bus.tx_done;
      r_tx_edge   <= bus.tx_done & ~r_tx_done_d;
      r_send_uart <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;

      case (r_state)
        IDLE: begin
          if (start) begin
            r_trig   <= trig_addr;
            r_before <= samples_before;
            r_after  <= samples_after;
            r_state  <= CALC;
          end
        end

        CALC: begin
          if (abort) begin
            r_state <= IDLE;
          end else if (w_bad) begin
            r_err   <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_sent_cnt <= '0;
            r_rd_req   <= 1'b1;
            r_state    <= RD_REQ;
          end
        end

        RD_REQ: begin
          if (abort) begin
            r_rd_req <= 1'b0;
            r_state  <= IDLE;
          end else if (bus.rd_ready) begin
            r_rd_req <= 1'b0;
            r_state  <= RD_WAIT;
          end
        end

        RD_WAIT: begin
          if (bus.rd_valid) begin
            // Data arriving with abort has nothing left to drain.
            if (abort) begin
              r_state <= IDLE;
            end else begin
              r_send_msg  <= bus.rd_data;
              r_send_uart <= 1'b1;
              r_state     <= TX_SEND;
            end
          end else if (abort) begin
            r_state <= ABORT_DRAIN;
          end
        end

        TX_SEND: begin
          r_state <= abort ? ABORT_DRAIN : TX_WAIT;
        end

        TX_WAIT: begin
          if (r_tx_edge) begin
            if (abort) begin
              r_state <= IDLE;
            end else begin
              r_sent_cnt <= r_sent_cnt + CNT_W'(1);
              if (w_last) begin
                r_state <= FINISH;
              end else begin
                r_rd_req <= 1'b1;
                r_state  <= RD_REQ;
              end
            end
          end else if (abort) begin
            r_state <= ABORT_DRAIN;
          end
        end

        FINISH: begin
          r_done  <= 1'b1;
          r_state <= IDLE;
        end

        ABORT_DRAIN: begin
          if (bus.rd_valid || r_tx_edge) begin
            r_state <= IDLE;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.rd_req    = r_rd_req;
  assign bus.rd_addr   = w_addr;
  assign bus.send_uart = r_send_uart;
  assign bus.send_msg  = r_send_msg;
  assign busy          = (r_state != IDLE);
  assign done          = r_done;
  assign err           = r_err;
  assign sent_cnt      = r_sent_cnt;

endmodule
`default_nettype wire

// File: tb/tb_uart_dump_scheduler.sv
`default_nettype none
// ==========================================================================
// Module : tb_uart_dump_scheduler
// Brief  : Scoreboard bench with memory and UART responder models.
// Rev    : 1.0 - initial release
// ==========================================================================
module tb_uart_dump_scheduler;
  import uart_dump_pkg::*;

  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = 8;

  logic              clk_PSRAM      = 1'b0;
  logic              reset          = 1'b1;
  logic              start          = 1'b0;
  logic              abort          = 1'b0;
  logic [ADDR_W-1:0] trig_addr      = '0;
  logic [CNT_W-1:0]  samples_before = '0;
  logic [CNT_W-1:0]  samples_after  = '0;
  logic              ready_en       = 1'b1;
  logic              busy;
  logic              done;
  logic              err;
  logic [CNT_W-1:0]  sent_cnt;

  int n_vec    = 0;
  int n_miss   = 0;
  int uart_cnt = 0;

  logic [ADDR_W-1:0] exp_addr[$];
  logic [15:0]       exp_msg[$];
  int                exp_evt[$];   // 1 = done, 2 = err

  uart_dump_scheduler_if #(.ADDR_W(ADDR_W)) bus ();

  uart_dump_scheduler #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) dut (
    .clk_PSRAM      (clk_PSRAM),
    .reset          (reset),
    .start          (start),
    .abort          (abort),
    .trig_addr      (trig_addr),
    .samples_before (samples_before),
    .samples_after  (samples_after),
    .bus            (bus.master),
    .busy           (busy),
    .done           (done),
    .err            (err),
    .sent_cnt       (sent_cnt)
  );

  always #5 clk_PSRAM = ~clk_PSRAM;

  assign bus.rd_ready = ready_en;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory word at address a reads back as 16'hA50a.
  task automatic push_word(input logic [ADDR_W-1:0] a);
    exp_addr.push_back(a);
    exp_msg.push_back(16'hA500 | {12'h000, a});
  endtask

  task automatic start_dump(input logic [ADDR_W-1:0] t, input logic [CNT_W-1:0] b,
                            input logic [CNT_W-1:0] a);
    @(negedge clk_PSRAM);
    trig_addr      = t;
    samples_before = b;
    samples_after  = a;
    start          = 1'b1;
    @(negedge clk_PSRAM);
    start          = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int max_cyc);
    int k = 0;
    while (busy && k < max_cyc) begin
      @(negedge clk_PSRAM);
      k++;
    end
    check({name, "_idle_timeout"}, {31'd0, busy}, 32'd0);
  endtask

  // Memory responder: two-cycle latency after acceptance.
  initial begin
    logic [ADDR_W-1:0] a;
    bus.rd_valid = 1'b0;
    bus.rd_data  = '0;
    forever begin
      @(negedge clk_PSRAM);
      if (!reset && bus.rd_req && bus.rd_ready) begin
        a = bus.rd_addr;
        repeat (2) @(negedge clk_PSRAM);
        bus.rd_valid = 1'b1;
        bus.rd_data  = 16'hA500 | {12'h000, a};
        @(negedge clk_PSRAM);
        bus.rd_valid = 1'b0;
      end
    end
  end

  // UART responder: flag drops two cycles after send, rises four cycles later and stays high.
  initial begin
    bus.tx_done = 1'b0;
    forever begin
      @(negedge clk_PSRAM);
      if (bus.send_uart) begin
        check("uart_overrun", uart_cnt, 32'd0);
        uart_cnt = 6;
      end else if (uart_cnt != 0) begin
        uart_cnt--;
        if (uart_cnt == 4) bus.tx_done = 1'b0;
        if (uart_cnt == 0) bus.tx_done = 1'b1;
      end
    end
  end

  // Scoreboard monitor.
  initial begin
    forever begin
      @(negedge clk_PSRAM);
      if (!reset) begin
        if (bus.rd_req && bus.rd_ready) begin
          if (exp_addr.size() == 0) check("rd_req_unexpected", 32'd1, 32'd0);
          else check("rd_addr", {28'd0, bus.rd_addr}, {28'd0, exp_addr.pop_front()});
        end
        if (bus.send_uart) begin
          if (exp_msg.size() == 0) check("send_uart_unexpected", 32'd1, 32'd0);
          else check("send_msg", {16'd0, bus.send_msg}, {16'd0, exp_msg.pop_front()});
        end
        if (done) begin
          if (exp_evt.size() == 0) check("done_unexpected", 32'd1, 32'd0);
          else check("done_evt", 32'd1, exp_evt.pop_front());
          check("busy_with_done", {31'd0, busy}, 32'd0);
        end
        if (err) begin
          if (exp_evt.size() == 0) check("err_unexpected", 32'd1, 32'd0);
          else check("err_evt", 32'd2, exp_evt.pop_front());
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, n_vec=%0d", n_vec);
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int k;

    repeat (3) @(negedge clk_PSRAM);
    check("rst_busy",      {31'd0, busy},          32'd0);
    check("rst_done",      {31'd0, done},          32'd0);
    check("rst_err",       {31'd0, err},           32'd0);
    check("rst_rd_req",    {31'd0, bus.rd_req},    32'd0);
    check("rst_rd_addr",   {28'd0, bus.rd_addr},   32'd0);
    check("rst_send_uart", {31'd0, bus.send_uart}, 32'd0);
    check("rst_send_msg",  {16'd0, bus.send_msg},  32'd0);
    check("rst_sent_cnt",  {24'd0, sent_cnt},      32'd0);
    reset = 1'b0;

    // Window 2..8 without wrap.
    for (int i = 2; i <= 8; i++) push_word(ADDR_W'(i));
    exp_evt.push_back(1);
    start_dump(4'd5, 8'd3, 8'd4);
    check("t1_rd_req_cyc1", {31'd0, bus.rd_req}, 32'd0);
    @(negedge clk_PSRAM);
    check("t1_rd_req_cyc2", {31'd0, bus.rd_req}, 32'd1);
    check("t1_first_addr",  {28'd0, bus.rd_addr}, 32'd2);
    wait_idle("t1", 400);
    check("t1_sent_cnt", {24'd0, sent_cnt}, 32'd7);

    // Wrap-around window; tx_done is still high from the previous dump.
    push_word(4'd14); push_word(4'd15); push_word(4'd0); push_word(4'd1); push_word(4'd2);
    exp_evt.push_back(1);
    start_dump(4'd1, 8'd3, 8'd2);
    wait_idle("t2", 400);
    check("t2_sent_cnt", {24'd0, sent_cnt}, 32'd5);

    // Empty window rejected.
    exp_evt.push_back(2);
    start_dump(4'd7, 8'd0, 8'd0);
    @(negedge clk_PSRAM);
    check("t3_err_pulse", {31'd0, err},        32'd1);
    check("t3_busy",      {31'd0, busy},       32'd0);
    check("t3_rd_req",    {31'd0, bus.rd_req}, 32'd0);
    @(negedge clk_PSRAM);
    check("t3_err_fall",  {31'd0, err},        32'd0);

    // Oversized window rejected.
    exp_evt.push_back(2);
    start_dump(4'd7, 8'd10, 8'd7);
    @(negedge clk_PSRAM);
    check("t3b_err_pulse", {31'd0, err}, 32'd1);

    // Single-word window.
    push_word(4'd3);
    exp_evt.push_back(1);
    start_dump(4'd3, 8'd0, 8'd1);
    wait_idle("t3c", 200);
    check("t3c_sent_cnt", {24'd0, sent_cnt}, 32'd1);

    // Abort while waiting on the third word's transmission.
    push_word(4'd2); push_word(4'd3); push_word(4'd4);
    start_dump(4'd5, 8'd3, 8'd4);
    s = 0;
    k = 0;
    while (s < 3 && k < 300) begin
      @(negedge clk_PSRAM);
      if (bus.send_uart) s++;
      k++;
    end
    check("t4_third_send", s, 32'd3);
    @(negedge clk_PSRAM);
    abort = 1'b1;
    @(negedge clk_PSRAM);
    abort = 1'b0;
    check("t4_drain_busy0", {31'd0, busy}, 32'd1);
    @(negedge clk_PSRAM);
    check("t4_drain_busy1", {31'd0, busy}, 32'd1);
    wait_idle("t4", 100);
    check("t4_tx_done_at_idle", {31'd0, bus.tx_done}, 32'd1);
    check("t4_sent_cnt", {24'd0, sent_cnt}, 32'd2);

    // Stalled read request cleared by reset, then a clean dump.
    ready_en = 1'b0;
    start_dump(4'd5, 8'd3, 8'd4);
    repeat (10) @(negedge clk_PSRAM);
    check("t5_rd_req_held", {31'd0, bus.rd_req}, 32'd1);
    check("t5_busy_held",   {31'd0, busy},       32'd1);
    reset = 1'b1;
    @(negedge clk_PSRAM);
    check("t5_rst_rd_req",   {31'd0, bus.rd_req},    32'd0);
    check("t5_rst_busy",     {31'd0, busy},          32'd0);
    check("t5_rst_rd_addr",  {28'd0, bus.rd_addr},   32'd0);
    check("t5_rst_send_msg", {16'd0, bus.send_msg},  32'd0);
    check("t5_rst_sent_cnt", {24'd0, sent_cnt},      32'd0);
    reset    = 1'b0;
    ready_en = 1'b1;
    push_word(4'd14); push_word(4'd15); push_word(4'd0); push_word(4'd1); push_word(4'd2);
    exp_evt.push_back(1);
    start_dump(4'd1, 8'd3, 8'd2);
    wait_idle("t5", 400);
    check("t5_sent_cnt", {24'd0, sent_cnt}, 32'd5);

    repeat (3) @(negedge clk_PSRAM);
    check("left_addr", exp_addr.size(), 32'd0);
    check("left_msg",  exp_msg.size(),  32'd0);
    check("left_evt",  exp_evt.size(),  32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
